// File: rtl/qft_sequencer.sv
// Row sequencer for the QFT datapath: issues one multiply/accumulate pass per
// state-vector row, an optional magnitude pass, and guards each wait with a watchdog.
module qft_sequencer #(
    parameter int N       = 2,
    parameter int WIDTH   = $clog2(N),
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abs_en,
    input  logic             abort,
    input  logic             update_state,
    output logic             strt_qft,
    output logic             strt_abs,
    output logic [WIDTH-1:0] row_idx,
    output logic             busy,
    output logic             ready,
    output logic             done,
    output logic             err
);

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] LAST_ROW = WIDTH'(N - 1);
    // Timeout fires when the counter would step onto TIMEOUT-1.
    localparam logic [WDW-1:0]   WD_LIMIT = WDW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_QFT,
        WAIT_QFT,
        ISSUE_ABS,
        WAIT_ABS,
        FINISH
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] row_d;
    logic [WDW-1:0]   wd, wd_d;
    logic             err_d;
    logic             abs_lat, abs_lat_d;
    logic [1:0]       rdy_cnt, rdy_cnt_d;
    logic             strt_qft_d, strt_abs_d, busy_d, done_d, ready_d;

    always_comb begin
        state_d   = state;
        row_d     = row_idx;
        wd_d      = wd;
        err_d     = err;
        abs_lat_d = abs_lat;

        unique case (state)
            IDLE: begin
                if (start && ready) begin
                    state_d   = ISSUE_QFT;
                    row_d     = '0;
                    err_d     = 1'b0;
                    abs_lat_d = abs_en;
                end
            end
            ISSUE_QFT: begin
                state_d = WAIT_QFT;
                wd_d    = '0;
            end
            WAIT_QFT: begin
                if (update_state) begin
                    wd_d = '0;
                    if (row_idx == LAST_ROW) begin
                        if (abs_lat) begin
                            state_d = ISSUE_ABS;
                        end else begin
                            state_d = FINISH;
                            row_d   = '0;
                        end
                    end else begin
                        state_d = ISSUE_QFT;
                        row_d   = row_idx + 1'b1;
                    end
                end else if (wd == WD_LIMIT) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    row_d   = '0;
                    wd_d    = '0;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            ISSUE_ABS: begin
                state_d = WAIT_ABS;
                wd_d    = '0;
            end
            WAIT_ABS: begin
                if (update_state) begin
                    state_d = FINISH;
                    row_d   = '0;
                    wd_d    = '0;
                end else if (wd == WD_LIMIT) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    row_d   = '0;
                    wd_d    = '0;
                end else begin
                    wd_d = wd + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides whatever the state decode chose above.
        if (abort && (state != IDLE)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            row_d   = '0;
            wd_d    = '0;
        end

        // Outputs are decoded from the next state so they register in step with it.
        strt_qft_d = (state_d == ISSUE_QFT);
        strt_abs_d = (state_d == ISSUE_ABS);
        busy_d     = (state_d inside {ISSUE_QFT, WAIT_QFT, ISSUE_ABS, WAIT_ABS});
        done_d     = (state_d == FINISH);

        rdy_cnt_d  = (rdy_cnt == 2'd2) ? 2'd2 : rdy_cnt + 2'd1;
        ready_d    = (rdy_cnt_d == 2'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row_idx  <= '0;
            wd       <= '0;
            err      <= 1'b0;
            abs_lat  <= 1'b0;
            rdy_cnt  <= '0;
            ready    <= 1'b0;
            strt_qft <= 1'b0;
            strt_abs <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            row_idx  <= row_d;
            wd       <= wd_d;
            err      <= err_d;
            abs_lat  <= abs_lat_d;
            rdy_cnt  <= rdy_cnt_d;
            ready    <= ready_d;
            strt_qft <= strt_qft_d;
            strt_abs <= strt_abs_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: doc/qft_sequencer.md
QFT_SEQUENCER -- requirements
Module: qft_sequencer

Interface
REQ-001 Parameter N, default 2: number of state-vector rows; power of two, >= 2.
REQ-002 Parameter WIDTH, default $clog2(N): row index width.
REQ-003 Parameter TIMEOUT, default 64: max cycles waiting for one completion; must exceed 2*N+4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request; honoured only in IDLE with ready=1.
REQ-007 abs_en  input  1  sampled with start; 1 = run a magnitude pass after the last row.
REQ-008 abort  input  1  cancel the current run.
REQ-009 update_state  input  1  one-cycle completion pulse from the multiply/accumulate control FSM.
REQ-010 strt_qft  output  1  one-cycle pulse requesting one row multiply-accumulate pass.
REQ-011 strt_abs  output  1  one-cycle pulse requesting the magnitude pass.
REQ-012 row_idx  output  WIDTH  row currently being computed.
REQ-013 busy  output  1  high from the cycle after an accepted start until the cycle done or err is raised.
REQ-014 ready  output  1  low for the first 2 cycles after reset release, then high.
REQ-015 done  output  1  one-cycle pulse on successful completion.
REQ-016 err  output  1  sticky timeout/abort flag; cleared only by the next accepted start or by reset.

Function
REQ-017 States SHALL be IDLE, ISSUE_QFT, WAIT_QFT, ISSUE_ABS, WAIT_ABS and FINISH; all outputs SHALL be registered.
REQ-018 IDLE: on start=1 and ready=1, the block SHALL latch abs_en, clear err, set row_idx=0 and go to ISSUE_QFT; strt_qft SHALL rise on the next cycle.
REQ-019 ISSUE_QFT: strt_qft=1 for exactly one cycle, then WAIT_QFT with the watchdog counter cleared.
REQ-020 WAIT_QFT, update_state=1, row_idx<N-1: row_idx SHALL increment and the state SHALL become ISSUE_QFT, giving strt_qft 1 cycle after update_state.
REQ-021 WAIT_QFT, update_state=1, row_idx=N-1: the next state SHALL be ISSUE_ABS if the latched abs_en=1, else FINISH; row_idx SHALL not wrap until FINISH.
REQ-022 ISSUE_ABS: strt_abs=1 for one cycle, then WAIT_ABS with the watchdog counter cleared; update_state there SHALL lead to FINISH.
REQ-023 FINISH: done=1 and row_idx=0 for one cycle, busy=0, then IDLE.
REQ-024 Watchdog: in WAIT_* the counter SHALL increment every cycle without update_state; on reaching TIMEOUT-1, err=1, busy=0 and the state SHALL become IDLE with no done pulse.
REQ-025 Abort SHALL have priority over update_state and timeout in any non-IDLE state: err=1, busy=0, row_idx=0, next state IDLE, and no further strt pulse.
REQ-026 The block SHALL ignore start while busy, and SHALL ignore update_state outside WAIT_QFT/WAIT_ABS.
REQ-027 strt_qft and strt_abs SHALL never both be high and SHALL never be high on consecutive cycles.
REQ-028 The ready counter SHALL saturate at 2 and restart only on reset.

Reset
REQ-029 While rst=0: state IDLE; strt_qft, strt_abs, busy, done, err and ready = 0; row_idx=0; all counters = 0; the latched abs_en = 0.
REQ-030 Reset asserted mid-run SHALL abandon the run immediately with no done and no err.

Verification
REQ-031 Scenario 1: N=4, abs_en=0, start, each strt_qft answered by update_state 8 cycles later -> four strt_qft with row_idx 0,1,2,3, no strt_abs, done 1 cycle after the 4th update_state, err=0.
REQ-032 Scenario 2: N=4, abs_en=1 -> four strt_qft then one strt_abs 1 cycle after the 4th update_state; done 1 cycle after the ABS update_state.
REQ-033 Scenario 3: start at 1 cycle after reset release -> ignored (ready=0); start at 3 cycles after release -> accepted.
REQ-034 Scenario 4: TIMEOUT=16, update_state withheld after the 2nd strt_qft -> err=1 and busy=0 16 cycles after that pulse; no done; err cleared by the next start.
REQ-035 Scenario 5: abort and update_state in the same cycle during WAIT_QFT -> err=1, IDLE, no further strt_qft; a stray update_state in IDLE -> no output change.
REQ-036 Scenario 6: rst=0 during WAIT_ABS -> all outputs at reset values immediately; a new start after ready runs normally from row 0.
